// File: rtl/or4_x4_pkg.sv
// Shared defaults, types and helpers for the or4_x4 edge-counting OR gate.
package or4_x4_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 0;
  localparam int NUM_IN          = 4;

  typedef logic [NUM_IN-1:0] in_vec_t;

  // Registered view of the sampled OR: level and its rising-edge pulse.
  typedef struct packed {
    logic zn_q;
    logic hit;
  } edge_st_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/or4_x4_sync.sv
// N-stage input synchronizer for the OR operands; STAGES == 0 collapses to a wire.
module or4_x4_sync
  import or4_x4_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF,
  parameter int W      = NUM_IN
) (
  input  logic         ck,
  input  logic         rn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (STAGES == 0) begin : g_pass
    logic unused_ck_rn;
    assign unused_ck_rn = ck ^ rn;
    assign q = d;
  end else begin : g_pipe
    logic [STAGES-1:0][W-1:0] pipe;

    always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
        pipe <= '0;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[STAGES-1];
  end

endmodule

// File: rtl/or4_x4.sv
// 4-input OR with registered output, rising-edge pulse, saturating edge counter
// and per-input sticky flags.
module or4_x4
  import or4_x4_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              A1,
  input  logic              A2,
  input  logic              A3,
  input  logic              A4,
  input  logic              CLR,
  output logic              ZN,
  output logic              ZN_Q,
  output logic              HIT,
  output logic [CNT_W-1:0]  RISE_CNT,
  output logic [NUM_IN-1:0] STICKY
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  in_vec_t  a_raw;
  in_vec_t  a_smp;
  logic     s;
  logic     rise;
  edge_st_t est;

  // Bit i-1 carries Ai so STICKY lines up with the operand numbering.
  assign a_raw = {A4, A3, A2, A1};

  // Pure combinational path: unaffected by clock, reset or clear.
  assign ZN = A1 | A2 | A3 | A4;

  or4_x4_sync #(
    .STAGES (SYNC_STAGES),
    .W      (NUM_IN)
  ) u_sync (
    .ck (CK),
    .rn (RN),
    .d  (a_raw),
    .q  (a_smp)
  );

  assign s    = |a_smp;
  assign rise = s & ~est.zn_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      est <= '0;
    end else begin
      est.zn_q <= s;
      est.hit  <= rise;
    end
  end

  assign ZN_Q = est.zn_q;
  assign HIT  = est.hit;

  // Counter moves on the same edge that raises HIT; a clear on that edge wins.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      RISE_CNT <= '0;
      STICKY   <= '0;
    end else if (CLR) begin
      RISE_CNT <= '0;
      STICKY   <= '0;
    end else begin
      if (rise) RISE_CNT <= CNT_W'(sat_inc(32'(RISE_CNT), 32'(CNT_MAX)));
      STICKY <= STICKY | a_smp;
    end
  end

endmodule

// File: tb/tb_or4_x4.sv
// Scoreboard bench for or4_x4: two instances (no sync / 2-stage sync) checked
// against a history-based reference model plus directed scenario checks.
module tb_or4_x4;

  logic       ck;
  logic       rn;
  logic [3:0] a;
  logic       clr;
  bit         ck_en;

  logic       zn0, znq0, hit0;
  logic [3:0] cnt0;
  logic [3:0] st0;
  logic       zn2, znq2, hit2;
  logic [7:0] cnt2;
  logic [3:0] st2;

  int errors = 0;
  int checks = 0;

  or4_x4 #(.CNT_W(4), .SYNC_STAGES(0)) dut0 (
    .CK(ck), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .CLR(clr),
    .ZN(zn0), .ZN_Q(znq0), .HIT(hit0), .RISE_CNT(cnt0), .STICKY(st0)
  );

  or4_x4 #(.CNT_W(8), .SYNC_STAGES(2)) dut2 (
    .CK(ck), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .CLR(clr),
    .ZN(zn2), .ZN_Q(znq2), .HIT(hit2), .RISE_CNT(cnt2), .STICKY(st2)
  );

  always begin
    #5;
    if (ck_en) ck = ~ck;
  end

  typedef struct {
    logic        zn_q;
    logic        hit;
    int unsigned cnt;
    logic [3:0]  st;
  } exp_t;

  typedef struct {
    exp_t e0;
    exp_t e2;
  } pair_t;

  pair_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input history since reset; each instance samples the
  // entry LAT edges back, and counts/flags are derived from those samples.
  logic [3:0]  hist[$];
  int          lat[2]  = '{0, 2};
  int unsigned cmax[2] = '{15, 255};
  int unsigned mcnt[2];
  logic [3:0]  mst[2];
  bit          mprev[2];

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = 0;
      mst[d]   = 4'b0;
      mprev[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [3:0] av, input logic cv, output exp_t e0, output exp_t e2);
    exp_t r[2];
    hist.push_back(av);
    for (int d = 0; d < 2; d++) begin
      int         idx;
      logic [3:0] sv;
      bit         s;
      idx = hist.size() - 1 - lat[d];
      sv  = (idx >= 0) ? hist[idx] : 4'b0;
      s   = (sv != 4'b0);
      r[d].zn_q = s;
      r[d].hit  = s && !mprev[d];
      mprev[d]  = s;
      if (cv) begin
        mcnt[d] = 0;
        mst[d]  = 4'b0;
      end else begin
        if (r[d].hit && mcnt[d] < cmax[d]) mcnt[d]++;
        mst[d] = mst[d] | sv;
      end
      r[d].cnt = mcnt[d];
      r[d].st  = mst[d];
    end
    e0 = r[0];
    e2 = r[1];
  endtask

  task automatic cycle(input logic [3:0] av, input logic cv);
    pair_t p;
    a   = av;
    clr = cv;
    @(posedge ck);
    model_edge(av, cv, p.e0, p.e2);
    sbq.push_back(p);
    #1;
  endtask

  // Monitor: one expected entry per clocked cycle, compared at the falling edge.
  always @(negedge ck) begin : mon
    pair_t p;
    if (ck_en) chk("zn_track", 32'(zn0 & zn2), 32'(a != 4'b0));
    if (sbq.size() > 0) begin
      p = sbq.pop_front();
      chk("znq0", 32'(znq0), 32'(p.e0.zn_q));
      chk("hit0", 32'(hit0), 32'(p.e0.hit));
      chk("cnt0", 32'(cnt0), p.e0.cnt);
      chk("st0",  32'(st0),  32'(p.e0.st));
      chk("znq2", 32'(znq2), 32'(p.e2.zn_q));
      chk("hit2", 32'(hit2), 32'(p.e2.hit));
      chk("cnt2", 32'(cnt2), p.e2.cnt);
      chk("st2",  32'(st2),  32'(p.e2.st));
    end
  end

  logic [3:0] seq6[6]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
  logic       hexp6[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    ck = 1'b0; rn = 1'b0; a = 4'b0; clr = 1'b0; ck_en = 1'b0;
    model_reset();
    #2;
    chk("rst_znq0", 32'(znq0), 32'd0);
    chk("rst_hit0", 32'(hit0), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_st0",  32'(st0),  32'd0);
    chk("rst_cnt2", 32'(cnt2), 32'd0);

    // Truth table with the clock stopped and reset held.
    for (int p = 0; p < 16; p++) begin
      a = p[3:0];
      #5;
      chk("tt_zn0", 32'(zn0), 32'(p != 0));
      chk("tt_zn2", 32'(zn2), 32'(p != 0));
    end

    // Reset isolation.
    a = 4'b0001;
    #5;
    chk("iso_zn",   32'(zn0),  32'd1);
    chk("iso_znq",  32'(znq0), 32'd0);
    chk("iso_hit",  32'(hit0), 32'd0);
    chk("iso_cnt",  32'(cnt0), 32'd0);
    chk("iso_st",   32'(st0),  32'd0);

    // Release with S already high: first edge must pulse and count.
    ck_en = 1'b1;
    @(posedge ck);
    #1;
    rn = 1'b1;
    model_reset();
    cycle(4'b0001, 1'b0);
    chk("first_hit", 32'(hit0), 32'd1);
    chk("first_cnt", 32'(cnt0), 32'd1);

    // Edge count on A3.
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(seq6[i], 1'b0);
      chk("a3_hit", 32'(hit0), 32'(hexp6[i]));
    end
    chk("a3_cnt", 32'(cnt0), 32'd2);
    chk("a3_st",  32'(st0),  32'b0100);

    // Saturation of the 4-bit counter.
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0001, 1'b0);
      cycle(4'b0000, 1'b0);
    end
    chk("sat_cnt", 32'(cnt0), 32'd15);

    // Clear colliding with a HIT edge.
    cycle(4'b0000, 1'b0);
    cycle(4'b0001, 1'b1);
    chk("clr_hit", 32'(hit0), 32'd1);
    chk("clr_cnt", 32'(cnt0), 32'd0);
    chk("clr_st",  32'(st0),  32'd0);
    cycle(4'b0001, 1'b0);
    chk("post_clr_cnt", 32'(cnt0), 32'd0);
    chk("post_clr_st",  32'(st0),  32'b0001);
    chk("post_clr_hit", 32'(hit0), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] av;
      logic       cv;
      av = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cv = ($urandom_range(0, 15) == 0);
      cycle(av, cv);
    end

    // Constant inputs: no further pulses.
    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b0);
    chk("hold_hit", 32'(hit0), 32'd0);

    // Async reset with a count of 7 in flight.
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(4'b0010, 1'b0);
      cycle(4'b0000, 1'b0);
    end
    chk("mid_cnt", 32'(cnt0), 32'd7);
    a = 4'b0010;
    #6;
    rn = 1'b0;
    #1;
    chk("ar_znq0", 32'(znq0), 32'd0);
    chk("ar_hit0", 32'(hit0), 32'd0);
    chk("ar_cnt0", 32'(cnt0), 32'd0);
    chk("ar_st0",  32'(st0),  32'd0);
    chk("ar_cnt2", 32'(cnt2), 32'd0);
    chk("ar_st2",  32'(st2),  32'd0);
    chk("ar_zn",   32'(zn0),  32'd1);
    a = 4'b0000;
    #1;
    chk("ar_zn_lo", 32'(zn0), 32'd0);
    a = 4'b1000;
    #1;
    chk("ar_zn_hi", 32'(zn2), 32'd1);
    @(posedge ck);
    @(posedge ck);
    #1;
    chk("ar_hold_cnt", 32'(cnt0), 32'd0);
    rn = 1'b1;
    model_reset();
    for (int i = 0; i < 60; i++) cycle(4'($urandom_range(0, 15)), 1'b0);
    cycle(4'b0000, 1'b0);

    repeat (3) @(negedge ck);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
